// File: rtl/ram_banked_if.sv
// Bus bundle for ram_banked: write data, word address, load/clear strobes,
// registered read data and clear-busy flag.
interface ram_banked_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic [DATA_W-1:0] in;
    logic [ADDR_W-1:0] address;
    logic              load;
    logic              clear;
    logic [DATA_W-1:0] out;
    logic              busy;

    modport master (output in, address, load, clear, input out, busy);
    modport slave  (input in, address, load, clear, output out, busy);
endinterface

// File: rtl/ram_banked.sv
// Banked single-port RAM with 1-cycle registered read and a parallel clear sweep.
// RAM_BANKED_WRITE_FIRST_EN: forward write data to out on a same-cycle write (default read-first).
module ram_banked #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 12,
    parameter int BANK_BITS = 3
) (
    input logic         clk,
    input logic         rst_n,
    ram_banked_if.slave bus
);
    localparam int WORD_W = ADDR_W - BANK_BITS;
    localparam int BANKS  = 1 << BANK_BITS;
    localparam int S      = 1 << WORD_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state_reg, state_next;
    logic [WORD_W-1:0]   ptr_reg, ptr_next;
    logic                busy_reg, busy_next;
    logic [DATA_W-1:0]   out_reg, out_next;

    logic [BANK_BITS-1:0] bank_sel;
    logic [WORD_W-1:0]    word_idx;
    logic                 write_en;
    logic [DATA_W-1:0]    bank_rdata [BANKS];

    assign bank_sel = bus.address[ADDR_W-1 -: BANK_BITS];
    assign word_idx = bus.address[WORD_W-1:0];
    // Clear wins over load; reset also blocks writes so a mid-sweep abort leaves the current word intact.
    assign write_en = rst_n && (state_reg == IDLE) && bus.load && !bus.clear;

    generate
        for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
            logic [DATA_W-1:0] mem [S];

            always_ff @(posedge clk) begin
                if (rst_n) begin
                    if (state_reg == CLEAR) begin
                        mem[ptr_reg] <= '0;
                    end else if (write_en && (bank_sel == BANK_BITS'(gi))) begin
                        mem[word_idx] <= bus.in;
                    end
                end
            end

            assign bank_rdata[gi] = mem[word_idx];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        busy_next  = busy_reg;
        out_next   = out_reg;
        case (state_reg)
            IDLE: begin
                out_next = bank_rdata[bank_sel];
`ifdef RAM_BANKED_WRITE_FIRST_EN
                if (bus.load && !bus.clear) begin
                    out_next = bus.in;
                end
`endif
                if (bus.clear) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                    busy_next  = 1'b1;
                end
            end
            CLEAR: begin
                ptr_next = ptr_reg + 1'b1;
                if (&ptr_reg) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            busy_reg  <= 1'b0;
            out_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            busy_reg  <= busy_next;
            out_reg   <= out_next;
        end
    end

    assign bus.out  = out_reg;
    assign bus.busy = busy_reg;
endmodule
